// File: rtl/fp_vec3_cross_seq.sv
// FP16 vec3 cross product c = a x b built around one shared multiplier and
// one shared adder. A sequencer issues six products, then three differences,
// and presents the result through a valid/ready handshake.

// Shared FP16 multiplier: round-to-nearest-even, subnormals flushed to zero.
module fp_mul_micro #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] c_o
);
    logic [15:0] res;
    logic [21:0] prod;
    logic [20:0] norm;
    logic [10:0] mant_r;
    logic [6:0]  e_sum, e_out;
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0] pipe_q [LAT];

    // Combinational multiply with specials, normalisation and rounding.
    always_comb begin
        s      = a_i[15] ^ b_i[15];
        a_nan  = (&a_i[14:10]) & (|a_i[9:0]);
        b_nan  = (&b_i[14:10]) & (|b_i[9:0]);
        a_inf  = (&a_i[14:10]) & ~(|a_i[9:0]);
        b_inf  = (&b_i[14:10]) & ~(|b_i[9:0]);
        a_zero = ~(|a_i[14:10]);
        b_zero = ~(|b_i[14:10]);
        prod   = 22'({1'b1, a_i[9:0]}) * 22'({1'b1, b_i[9:0]});
        norm   = prod[21] ? prod[20:0] : {prod[19:0], 1'b0};
        mant_r = {1'b0, norm[20:11]} + {10'd0, norm[10] & ((|norm[9:0]) | norm[11])};
        e_sum  = {2'b0, a_i[14:10]} + {2'b0, b_i[14:10]} + {6'd0, prod[21]} + {6'd0, mant_r[10]};
        e_out  = e_sum - 7'd15;
        if (a_nan || b_nan)
            res = 16'h7E00;
        else if (a_inf || b_inf)
            res = (a_zero || b_zero) ? 16'h7E00 : {s, 5'h1F, 10'd0};
        else if (a_zero || b_zero || (e_sum <= 7'd15))
            res = {s, 15'd0};
        else if (e_out >= 7'd31)
            res = {s, 5'h1F, 10'd0};
        else
            res = {s, e_out[4:0], mant_r[9:0]};
    end

    // Output pipeline; its depth is the unit latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= res;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign c_o = pipe_q[LAT-1];
endmodule

// Shared FP16 adder: round-to-nearest-even, subnormals flushed to zero.
module fp_add_micro #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] c_o
);
    logic [15:0] res, x, y;
    logic        ge, eff_sub, stk, a_nan, b_nan, a_inf, b_inf;
    logic [4:0]  d;
    logic [13:0] mx, my, ysh, yv, nrm;
    logic [14:0] sum;
    logic [3:0]  pos;
    logic [10:0] mant_r;
    logic [6:0]  e_sum, e_out;
    logic [15:0] pipe_q [LAT];

    // Combinational add: order by magnitude, align with sticky, normalise, round.
    always_comb begin
        a_nan   = (&a_i[14:10]) & (|a_i[9:0]);
        b_nan   = (&b_i[14:10]) & (|b_i[9:0]);
        a_inf   = (&a_i[14:10]) & ~(|a_i[9:0]);
        b_inf   = (&b_i[14:10]) & ~(|b_i[9:0]);
        ge      = a_i[14:0] >= b_i[14:0];
        x       = ge ? a_i : b_i;
        y       = ge ? b_i : a_i;
        eff_sub = x[15] ^ y[15];
        d       = x[14:10] - y[14:10];
        mx      = {1'b1, x[9:0], 3'b000};
        my      = {1'b1, y[9:0], 3'b000};
        ysh     = my >> d;
        stk     = |(my & ((14'd1 << d) - 14'd1));
        yv      = {ysh[13:1], ysh[0] | stk};
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, yv}) : ({1'b0, mx} + {1'b0, yv});
        pos     = 4'd0;
        for (int i = 0; i < 15; i++) if (sum[i]) pos = 4'(i);
        nrm     = 14'(sum << (4'd14 - pos));
        mant_r  = {1'b0, nrm[13:4]} + {10'd0, nrm[3] & ((|nrm[2:0]) | nrm[4])};
        e_sum   = {2'b0, x[14:10]} + {3'b0, pos} + {6'd0, mant_r[10]};
        e_out   = e_sum - 7'd13;
        if (a_nan || b_nan)
            res = 16'h7E00;
        else if (a_inf && b_inf && (a_i[15] != b_i[15]))
            res = 16'h7E00;
        else if (a_inf || b_inf)
            res = x;
        else if (x[14:10] == 5'd0)
            res = {x[15] & y[15], 15'd0};
        else if (y[14:10] == 5'd0)
            res = x;
        else if (sum == 15'd0)
            res = 16'h0000;
        else if (e_sum <= 7'd13)
            res = {x[15], 15'd0};
        else if (e_out >= 7'd31)
            res = {x[15], 5'h1F, 10'd0};
        else
            res = {x[15], e_out[4:0], mant_r[9:0]};
    end

    // Output pipeline; its depth is the unit latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= res;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign c_o = pipe_q[LAT-1];
endmodule

// Sequencer top.
// state | meaning
// IDLE  | in_ready high, waiting for operands
// MUL   | issuing six products, collecting p0..p5
// SUB   | issuing three differences, collecting c_x/c_y/c_z
// DONE  | out_valid high, result held until out_ready
module fp_vec3_cross_seq #(
    parameter int MUL_LAT = 1,
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    input  logic [15:0] a_z,
    input  logic [15:0] b_x,
    input  logic [15:0] b_y,
    input  logic [15:0] b_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c_x,
    output logic [15:0] c_y,
    output logic [15:0] c_z
);
    typedef enum logic [1:0] {IDLE, MUL, SUB, DONE} state_t;

    state_t             state_q;
    logic [15:0]        ax_q, ay_q, az_q, bx_q, by_q, bz_q;
    logic [15:0]        p_q [6];
    logic [15:0]        cx_q, cy_q, cz_q;
    logic [2:0]         iss_q, cap_q;
    logic [MUL_LAT-1:0] mvld_q;
    logic [ADD_LAT-1:0] avld_q;
    logic               in_ready_q, out_valid_q;
    logic               mul_go, add_go;
    logic [15:0]        mul_a, mul_b, mul_c, add_a, add_b, add_c;

    fp_mul_micro #(.LAT(MUL_LAT)) u_mul (
        .clk (clk), .rst (rst), .a_i (mul_a), .b_i (mul_b), .c_o (mul_c)
    );

    fp_add_micro #(.LAT(ADD_LAT)) u_add (
        .clk (clk), .rst (rst), .a_i (add_a), .b_i (add_b), .c_o (add_c)
    );

    // Operand selection for the shared units; a unit not being issued sees zeros.
    always_comb begin
        mul_go = (state_q == MUL) && (iss_q < 3'd6);
        add_go = (state_q == SUB) && (iss_q < 3'd3);
        mul_a  = '0;
        mul_b  = '0;
        add_a  = '0;
        add_b  = '0;
        if (mul_go) begin
            case (iss_q)
                3'd0:    begin mul_a = ay_q; mul_b = bz_q; end
                3'd1:    begin mul_a = az_q; mul_b = by_q; end
                3'd2:    begin mul_a = az_q; mul_b = bx_q; end
                3'd3:    begin mul_a = ax_q; mul_b = bz_q; end
                3'd4:    begin mul_a = ax_q; mul_b = by_q; end
                default: begin mul_a = ay_q; mul_b = bx_q; end
            endcase
        end
        if (add_go) begin
            case (iss_q)
                3'd0:    begin add_a = p_q[0]; add_b = {~p_q[1][15], p_q[1][14:0]}; end
                3'd1:    begin add_a = p_q[2]; add_b = {~p_q[3][15], p_q[3][14:0]}; end
                default: begin add_a = p_q[4]; add_b = {~p_q[5][15], p_q[5][14:0]}; end
            endcase
        end
    end

    // Transaction FSM, capture-valid tracking and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ax_q <= '0; ay_q <= '0; az_q <= '0;
            bx_q <= '0; by_q <= '0; bz_q <= '0;
            for (int i = 0; i < 6; i++) p_q[i] <= '0;
            cx_q <= '0; cy_q <= '0; cz_q <= '0;
            iss_q  <= '0;
            cap_q  <= '0;
            mvld_q <= '0;
            avld_q <= '0;
        end else begin
            mvld_q[0] <= mul_go;
            for (int i = 1; i < MUL_LAT; i++) mvld_q[i] <= mvld_q[i-1];
            avld_q[0] <= add_go;
            for (int i = 1; i < ADD_LAT; i++) avld_q[i] <= avld_q[i-1];
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ax_q <= a_x; ay_q <= a_y; az_q <= a_z;
                        bx_q <= b_x; by_q <= b_y; bz_q <= b_z;
                        iss_q      <= '0;
                        cap_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    if (mul_go) iss_q <= iss_q + 3'd1;
                    if (mvld_q[MUL_LAT-1]) begin
                        p_q[cap_q] <= mul_c;
                        cap_q      <= cap_q + 3'd1;
                        if (cap_q == 3'd5) begin
                            iss_q   <= '0;
                            cap_q   <= '0;
                            state_q <= SUB;
                        end
                    end
                end
                SUB: begin
                    if (add_go) iss_q <= iss_q + 3'd1;
                    if (avld_q[ADD_LAT-1]) begin
                        cap_q <= cap_q + 3'd1;
                        case (cap_q)
                            3'd0: cx_q <= add_c;
                            3'd1: cy_q <= add_c;
                            default: begin
                                cz_q        <= add_c;
                                iss_q       <= '0;
                                cap_q       <= '0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c_x       = cx_q;
    assign c_y       = cy_q;
    assign c_z       = cz_q;
endmodule

// File: tb/tb_fp_vec3_cross_seq.sv
// Bench for fp_vec3_cross_seq: a default-latency instance and a
// MUL_LAT=3/ADD_LAT=2 instance share stimulus; sel picks the one under test.
module tb_fp_vec3_cross_seq;
    typedef struct {
        logic [15:0] ax, ay, az, bx, by, bz;
        logic [15:0] cx, cy, cz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv, out_ready;
    logic        iv0, iv1, ir0, ir1, ov0, ov1;
    logic [15:0] a_x, a_y, a_z, b_x, b_y, b_z;
    logic [15:0] cx0, cy0, cz0, cx1, cy1, cz1;
    logic        o_ir, o_ov;
    logic [15:0] o_cx, o_cy, o_cz;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    vec_t        sb_q[$];
    vec_t        vecs[5];
    vec_t        sweep;

    assign iv0  = iv && (sel == 0);
    assign iv1  = iv && (sel == 1);
    assign o_ir = (sel == 1) ? ir1 : ir0;
    assign o_ov = (sel == 1) ? ov1 : ov0;
    assign o_cx = (sel == 1) ? cx1 : cx0;
    assign o_cy = (sel == 1) ? cy1 : cy0;
    assign o_cz = (sel == 1) ? cz1 : cz0;

    fp_vec3_cross_seq dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a_x(a_x), .a_y(a_y), .a_z(a_z), .b_x(b_x), .b_y(b_y), .b_z(b_z),
        .out_valid(ov0), .out_ready(out_ready), .c_x(cx0), .c_y(cy0), .c_z(cz0)
    );

    fp_vec3_cross_seq #(.MUL_LAT(3), .ADD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a_x(a_x), .a_y(a_y), .a_z(a_z), .b_x(b_x), .b_y(b_y), .b_z(b_z),
        .out_valid(ov1), .out_ready(out_ready), .c_x(cx1), .c_y(cy1), .c_z(cz1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // loose: an expected zero accepts either signed zero
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp, input bit loose);
        bit bad;
        checks++;
        if (loose && exp[14:0] == 15'd0) bad = (act[14:0] !== 15'd0);
        else                             bad = (act !== exp);
        if (bad) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        a_x = v.ax; a_y = v.ay; a_z = v.az;
        b_x = v.bx; b_y = v.by; b_z = v.bz;
    endtask

    task automatic accept(input vec_t v);
        int n = 0;
        while (o_ir !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        drive(v);
        iv = 1'b1;
        sb_q.push_back(v);
        acc_cyc = cyc;
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic collect(input int exp_lat);
        vec_t e;
        int n = 1;
        chk("busy_in_ready", {15'd0, o_ir}, 16'd0, 1'b0);
        while (o_ov !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk_int("latency", n, exp_lat);
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: result with no pending entry");
        end else begin
            e = sb_q.pop_front();
            chk("c_x", o_cx, e.cx, 1'b1);
            chk("c_y", o_cy, e.cy, 1'b1);
            chk("c_z", o_cz, e.cz, 1'b1);
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_drop", {15'd0, o_ov}, 16'd0, 1'b0);
        chk("in_ready_back", {15'd0, o_ir}, 16'd1, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hx, hy, hz;
        int prev;
        iv = 1'b0; out_ready = 1'b1;
        a_x = '0; a_y = '0; a_z = '0; b_x = '0; b_y = '0; b_z = '0;

        vecs[0] = '{16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h3C00};
        vecs[1] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'hC200, 16'h4600, 16'hC200};
        vecs[2] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4000, 16'h4400, 16'h4600, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4200, 16'h0000, 16'hC600, 16'h0000};
        vecs[4] = '{16'h3E00, 16'hC000, 16'h3800, 16'hBC00, 16'h4400, 16'h4000, 16'hC600, 16'hC300, 16'h4400};
        sweep   = '{16'h0000, 16'h0000, 16'hBC00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'hBC00, 16'h0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_in_ready", {15'd0, o_ir}, 16'd1, 1'b0);
            chk("rst_out_valid", {15'd0, o_ov}, 16'd0, 1'b0);
            chk("rst_c_x", o_cx, 16'h0000, 1'b0);
            chk("rst_c_y", o_cy, 16'h0000, 1'b0);
            chk("rst_c_z", o_cz, 16'h0000, 1'b0);
        end
        sel = 0;
        @(posedge clk); #1;

        // table of vectors, back to back at the minimum initiation interval
        for (int i = 0; i < 5; i++) begin
            prev = acc_cyc;
            accept(vecs[i]);
            if (i > 0) chk_int("init_interval", acc_cyc - prev, 13);
            collect(12);
            handoff();
        end

        // backpressure: hold the result while new operands are offered
        accept(vecs[1]);
        out_ready = 1'b0;
        collect(12);
        hx = o_cx; hy = o_cy; hz = o_cz;
        drive(vecs[3]);
        iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {15'd0, o_ov}, 16'd1, 1'b0);
            chk("bp_in_ready", {15'd0, o_ir}, 16'd0, 1'b0);
            chk("bp_c_x", o_cx, hx, 1'b0);
            chk("bp_c_y", o_cy, hy, 1'b0);
            chk("bp_c_z", o_cz, hz, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {15'd0, o_ov}, 16'd0, 1'b0);
        chk("bp_release_ready", {15'd0, o_ir}, 16'd1, 1'b0);
        sb_q.push_back(vecs[3]);
        @(posedge clk); #1;
        iv = 1'b0;
        collect(12);
        handoff();

        // reset five cycles into a transaction
        accept(vecs[1]);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {15'd0, o_ov}, 16'd0, 1'b0);
        chk("abort_c_x", o_cx, 16'h0000, 1'b0);
        chk("abort_c_y", o_cy, 16'h0000, 1'b0);
        chk("abort_c_z", o_cz, 16'h0000, 1'b0);
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {15'd0, o_ir}, 16'd1, 1'b0);
        chk("abort_out_valid2", {15'd0, o_ov}, 16'd0, 1'b0);
        accept(vecs[1]);
        collect(12);
        handoff();

        // longer unit latencies
        sel = 1;
        #1;
        accept(sweep);
        collect(15);
        handoff();
        prev = acc_cyc;
        accept(vecs[1]);
        chk_int("init_interval_sweep", acc_cyc - prev, 16);
        collect(15);
        handoff();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
